md_issue_ctrl: RTL

- Issue/occupancy controller placed directly upstream of the HI/LO multiply-divide unit.
- Accepts a mult/multu/div/divu from the EX stage and latches its operands and op code.
- Holds DA/DB/ALUOP stable at the MUL_DIV inputs for the architectural latency of the operation.
- Generates the pipeline stall for any HI/LO access, or any new mul/div, while the unit is occupied.

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_latency_cnt.sv | 36 +++
 rtl/md_issue_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: definitions shared by the multiply/divide issue controller.
//   - ALUOP codes for the four HI/LO producing operations and the idle code
//   - default busy latencies and counter width
//   - controller state encoding
//   - decode helpers is_md_op / is_div_op
package md_pkg;

    localparam logic [4:0] MD_MULT  = 5'b10001;
    localparam logic [4:0] MD_MULTU = 5'b10010;
    localparam logic [4:0] MD_DIV   = 5'b10011;
    localparam logic [4:0] MD_DIVU  = 5'b10100;
    localparam logic [4:0] MD_NOP   = 5'b00000;

    localparam int unsigned MD_MUL_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF = 10;
    localparam int unsigned MD_CNT_W_DEF      = 4;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } md_state_e;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_latency_cnt.sv
// md_latency_cnt: loadable down-counter tracking the remaining busy cycles
// of the multiply/divide unit.
//   clk        system clock
//   rst        synchronous active-high reset (count -> 0)
//   i_load     load i_load_val this edge (takes priority over decrement)
//   i_load_val latency to load
//   i_dec      decrement this edge (saturates at 0)
//   o_last     count == 1, i.e. the final busy cycle
module md_latency_cnt
    import md_pkg::*;
#(
    parameter int unsigned CNT_W = MD_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/occupancy controller in front of the HI/LO
// multiply-divide unit. Latches operands and op code of an accepted
// mult/multu/div/divu and holds them at the unit inputs for the op latency,
// and stalls decode for HI/LO accesses or new mul/div while occupied.
//   clk, rst     clock, synchronous active-high reset
//   start        EX holds a valid mul/div this cycle
//   op_in        ALUOP of the EX instruction
//   rs_val       forwarded rs operand
//   rt_val       forwarded rt operand
//   flush        EX instruction is being cancelled
//   hilo_use_d   decode holds mfhi/mflo/mthi/mtlo
//   md_in_d      decode holds mult/multu/div/divu
//   da_out       operand A to MUL_DIV
//   db_out       operand B to MUL_DIV
//   aluop_out    op code to MUL_DIV (MD_NOP when idle)
//   busy         unit occupied
//   done         pulse in the last busy cycle
//   stall        freeze PC/IF-ID, bubble into EX
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MD_MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = MD_DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = MD_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  op_in,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        hilo_use_d,
    input  logic        md_in_d,
    output logic [31:0] da_out,
    output logic [31:0] db_out,
    output logic [4:0]  aluop_out,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] w_load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start seen while BUSY is ignored: only IDLE can accept, and flush
    // only cancels an instruction that has not been accepted yet.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !flush && is_md_op(op_in)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    done        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Covers the accept cycle too, so a dependent decode instruction is
    // held before the unit's busy flag is even registered.
    assign stall      = (hilo_use_d | md_in_d) & (busy | w_accept);
    assign w_load_val = is_div_op(op_in) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            da_out    <= '0;
            db_out    <= '0;
            aluop_out <= MD_NOP;
        end else if (w_accept) begin
            da_out    <= rs_val;
            db_out    <= rt_val;
            aluop_out <= op_in;
        end else if (done) begin
            // Operands stay put; the NOP code makes MUL_DIV hold HI/LO.
            aluop_out <= MD_NOP;
        end
    end

    md_latency_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_dec      (busy),
        .o_last     (w_last)
    );

endmodule
